spi_device: RTL and testbench

- SPI slave front end that sits directly upstream of the interface control block.
- Synchronises the external SPI pins (mode 0, MSB first) into the system clock domain.
- Delivers each received byte as a one-cycle strobe, and shifts out the response bytes that the control block loads.
- Exports the deselect level that the control block uses to abort commands and start transmission.

---
 rtl/spi_device.sv | 183 ++++++++++++++++++
 tb/tb_spi_device.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device.sv
// -----------------------------------------------------------------------------
// spi_device
//
// SPI slave front end (mode 0, MSB first) running entirely in the system clock
// domain. The SPI pins are oversampled through synchronisers, and their edges
// are detected against one extra delay flop. Each received byte is delivered
// as a one-cycle strobe. Response bytes that the control block loads are
// shifted out on MISO.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset (synchronously released upstream)
//   spi_sck      SPI clock pin (asynchronous)
//   spi_cs_n     SPI chip select pin, active low (asynchronous)
//   spi_mosi     SPI data in pin (asynchronous)
//   spi_miso     SPI data out, registered
//   spi_miso_oe  MISO output enable, high while selected
//   spi_cs       synchronised deselect level (1 = not selected)
//   rx_data      last complete received byte
//   rx_strobe    one-cycle pulse, rx_data valid
//   tx_data      next byte to shift out
//   tx_strobe    one-cycle pulse, capture tx_data into the holding register
//   tx_underrun  one-cycle pulse, byte boundary reached with no fresh tx byte
// -----------------------------------------------------------------------------
module spi_device #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       spi_cs,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_underrun
);

  // Input synchronisers; bit 0 samples the pin.
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_dly_q;
  logic                   cs_dly_q;

  // Marks when the synchroniser chain and the delay flops hold real pin samples.
  // The marking is done by shifting ones in after reset. Until it is full, the
  // preset values would fake edges. An example is cs_n held low through reset,
  // which must not look like a select.
  logic [SYNC_STAGES:0]   flush_q;

  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] rx_shift_q,  rx_shift_d;
  logic [7:0] tx_shift_q,  tx_shift_d;
  logic [7:0] hold_q,      hold_d;
  logic       hold_vld_q,  hold_vld_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic       underrun_q,  underrun_d;
  logic       miso_q,      miso_d;

  logic       sck_s, cs_s, mosi_s, flushed;
  logic       sel_edge, desel_edge, sck_rise, sck_fall;
  logic [7:0] load_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      flush_q     <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign flushed = flush_q[SYNC_STAGES];

  assign sel_edge   = flushed &  cs_dly_q & ~cs_s;
  assign desel_edge = flushed & ~cs_dly_q &  cs_s;
  // SCK edges count only while synced cs_n is low. This makes a deselect
  // override a coincident rising edge.
  assign sck_rise   = flushed & ~cs_s &  sck_s & ~sck_dly_q;
  assign sck_fall   = flushed & ~cs_s & ~sck_s &  sck_dly_q;

  // A strobe in the same cycle as a load bypasses the holding register.
  assign load_val = tx_strobe  ? tx_data :
                    hold_vld_q ? hold_q  : IDLE_BYTE;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    underrun_d  = 1'b0;
    miso_d      = miso_q;

    if (tx_strobe) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
    end

    if (desel_edge) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      hold_vld_d = 1'b0;
      miso_d     = 1'b0;
    end else if (sel_edge) begin
      bit_cnt_d  = 3'd0;
      tx_shift_d = load_val;
      miso_d     = load_val[7];
      hold_vld_d = 1'b0;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d   = {rx_shift_q[6:0], mosi_s};
        rx_strobe_d = 1'b1;
      end
    end else if (sck_fall) begin
      if (bit_cnt_q != 3'd0) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
        miso_d     = tx_shift_q[6];
      end else begin
        // Byte boundary: fetch the next response byte.
        tx_shift_d = load_val;
        miso_d     = load_val[7];
        hold_vld_d = 1'b0;
        underrun_d = ~tx_strobe & ~hold_vld_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_cs      = cs_dly_q;
  assign spi_miso_oe = ~cs_dly_q;
  assign spi_miso    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_strobe   = rx_strobe_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_device.sv
module tb_spi_device;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       spi_cs;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_strobe = 1'b0;
  logic       tx_underrun;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  int und_pulses = 0;

  spi_device #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .spi_cs(spi_cs),
    .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  // Count pulse cycles; each one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (rx_strobe === 1'b1)   rx_pulses  <= rx_pulses + 1;
    if (tx_underrun === 1'b1) und_pulses <= und_pulses + 1;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One SPI byte, half-period 8 clk. MISO is sampled just before each rising edge.
  // strobe_after_rx: pulse tx_strobe(tv) two clk after this byte's rx_strobe.
  // strobe_at_load: pulse tx_strobe(tv) in the clk where the final falling edge
  // is detected (sck pin low + SYNC_STAGES clk).
  task automatic xfer(input logic [7:0] mo, input bit strobe_after_rx,
                      input bit strobe_at_load, input logic [7:0] tv,
                      output logic [7:0] mi);
    int cd;
    bit fired;
    cd = 0;
    fired = 0;
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      repeat (8) @(negedge clk);
      mi[i] = spi_miso;
      spi_sck = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        tx_strobe = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            tx_strobe = 1'b1;
            tx_data = tv;
          end
        end
        if (strobe_after_rx && !fired && rx_strobe === 1'b1) begin
          cd = 2;
          fired = 1;
        end
      end
      tx_strobe = 1'b0;
      spi_sck = 1'b0;
    end
    if (strobe_at_load) begin
      repeat (2) @(negedge clk);
      tx_strobe = 1'b1;
      tx_data = tv;
      @(negedge clk);
      tx_strobe = 1'b0;
    end
    $display("xfer mosi=%h miso=%h rx_data=%h", mo, mi, rx_data);
  endtask

  task automatic partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi;
    int rx_before;

    // 1: reset with pins idle
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk1("rst_spi_cs", spi_cs, 1'b1);
      chk1("rst_oe", spi_miso_oe, 1'b0);
      chk1("rst_rx_strobe", rx_strobe, 1'b0);
      chk8("rst_rx_data", rx_data, 8'h00);
    end
    $display("reset idle checked");

    // 2: select, first byte 0x12; tx byte A5 loaded after its rx_strobe (3)
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    chk1("sel_spi_cs", spi_cs, 1'b0);
    chk1("sel_oe", spi_miso_oe, 1'b1);
    xfer(8'h12, 1'b1, 1'b0, 8'hA5, mi);
    repeat (4) @(negedge clk);
    chk8("b1_miso", mi, 8'h00);
    chk8("b1_rx_data", rx_data, 8'h12);
    chkn("b1_rx_pulses", rx_pulses, 1);
    chkn("b1_underruns", und_pulses, 0);

    // 3: second byte carries A5 on MISO
    xfer(8'hFF, 1'b0, 1'b0, 8'h00, mi);
    repeat (4) @(negedge clk);
    chk8("b2_miso", mi, 8'hA5);
    chk8("b2_rx_data", rx_data, 8'hFF);
    chkn("b2_rx_pulses", rx_pulses, 2);
    chkn("b2_underruns", und_pulses, 1);

    // 4: third byte with nothing loaded -> idle byte
    xfer(8'h81, 1'b0, 1'b0, 8'h00, mi);
    repeat (4) @(negedge clk);
    chk8("b3_miso", mi, 8'h00);
    chk8("b3_rx_data", rx_data, 8'h81);
    chkn("b3_rx_pulses", rx_pulses, 3);
    chkn("b3_underruns", und_pulses, 2);

    // 5: abort after 5 rising edges
    partial(5);
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (spi_cs === 1'b1) break;
    end
    chk1("desel_spi_cs", spi_cs, 1'b1);
    chk1("desel_oe", spi_miso_oe, 1'b0);
    chk1("desel_miso", spi_miso, 1'b0);
    repeat (8) @(negedge clk);
    chkn("desel_rx_pulses", rx_pulses, 3);
    chk8("desel_rx_data_kept", rx_data, 8'h81);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer(8'h3C, 1'b0, 1'b0, 8'h00, mi);
    repeat (4) @(negedge clk);
    chk8("b4_rx_data", rx_data, 8'h3C);
    chk8("b4_miso", mi, 8'h00);
    chkn("b4_rx_pulses", rx_pulses, 4);
    chkn("b4_underruns", und_pulses, 3);

    // 6: reset mid-byte with cs_n held low
    partial(3);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk1("midrst_spi_cs", spi_cs, 1'b1);
    chk1("midrst_oe", spi_miso_oe, 1'b0);
    chk1("midrst_miso", spi_miso, 1'b0);
    chk8("midrst_rx_data", rx_data, 8'h00);
    chk1("midrst_rx_strobe", rx_strobe, 1'b0);
    chk1("midrst_underrun", tx_underrun, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk1("post_rst_spi_cs", spi_cs, 1'b0);
    chk1("post_rst_miso", spi_miso, 1'b0);
    rx_before = rx_pulses;
    // tx_strobe coincides with the byte-boundary load: bypass, no underrun
    xfer(8'h96, 1'b0, 1'b1, 8'hC3, mi);
    repeat (4) @(negedge clk);
    chk8("b5_rx_data", rx_data, 8'h96);
    chkn("b5_rx_pulses", rx_pulses, rx_before + 1);
    chkn("b5_underruns", und_pulses, 3);
    xfer(8'h00, 1'b0, 1'b0, 8'h00, mi);
    repeat (4) @(negedge clk);
    chk8("b6_miso_bypass", mi, 8'hC3);
    chk8("b6_rx_data", rx_data, 8'h00);
    chkn("b6_rx_pulses", rx_pulses, rx_before + 2);
    chkn("b6_underruns", und_pulses, 4);

    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk1("end_spi_cs", spi_cs, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
